traffic_state_gen: RTL and testbench
====================================

Name: traffic_state_gen

Overview:
- Sequential state generator for the traffic-light path. Produces the num_of_bit State code that the traffic-light decoder consumes, so it is the encoder/driver end of that interface.
- Advances State once per prescaled tick through green, yellow and red windows. Supports a pedestrian request that shortens green and a ForceRed override.
- Also drives registered Red/Yellow/Green copies for local monitoring and cross-checking against the decoder.

Parameters:
- num_of_bit, 4, width of State.
- green_yellow_ratio, 4, green window length = green_yellow_ratio * yellow_len ticks.
- yellow_len, 2, yellow window length in ticks (≥1).
- red_len, 6, red window length in ticks (≥1).
- tick_div, 15, clock cycles per tick (≥1).
- min_green, 2, minimum green ticks before a pedestrian request may end green (1..G_LEN).

Ports:
- clk  input  1  clock, all logic rising-edge.
- rst  input  1  synchronous reset, active-high.
- Enable  input  1  gates the prescaler; low freezes tick generation.
- PedReq  input  1  pedestrian request, one-cycle or level; latched internally.
- ForceRed  input  1  level; drive and hold red while high.
- State  output  num_of_bit  cycle position code to the decoder.
- Red  output  1  registered red indication.
- Yellow  output  1  registered yellow indication.
- Green  output  1  registered green indication.
- Tick  output  1  one-cycle pulse on each prescaler wrap.
- PedAck  output  1  one-cycle pulse when a latched request shortens green.

Behaviour:
- Derived constants:
  - G_LEN = green_yellow_ratio*yellow_len; Y0 = G_LEN; R0 = G_LEN+yellow_len; CYCLE = R0+red_len.
  - Defaults: G_LEN=8, Y0=8, R0=10, CYCLE=16.
  - CYCLE > 2^num_of_bit or min_green > G_LEN is an elaboration error.
- State code:
  - Green for State 0..G_LEN-1; Yellow for Y0..R0-1; Red for R0..CYCLE-1. Exactly one colour output is high.
  - Colour outputs are registered in the same clock edge as State, so they always match the current State.
- Reset: State=R0, Red=1, Yellow=0, Green=0, Tick=0, PedAck=0, prescaler=0, ped latch=0, FSM=RUN. Reset mid-operation aborts everything on the next edge.
- Prescaler:
  - Counts 0..tick_div-1 while Enable=1 and holds while Enable=0.
  - Tick=1 for the cycle after the prescaler leaves tick_div-1; the prescaler wraps to 0. With tick_div=1 and Enable=1, Tick is high every cycle.
- Tick latency: all State changes take effect on the clock edge where the internal tick condition holds. State and Tick update on the same edge.
- FSM states:
  - RUN: on tick, State = (State==CYCLE-1) ? 0 : State+1, i.e. wraps at CYCLE, not at 2^num_of_bit.
  - PED: not a separate state. In RUN, on tick, if the ped latch is set, State is green and State ≥ min_green-1, then State jumps to Y0 and PedAck pulses on the same edge. The latch clears on that edge.
  - FORCE_Y: entered when ForceRed=1 while State is green. On the next edge State jumps to Y0. Yellow then advances on ticks; on the tick leaving R0-1, go to FORCE_HOLD. Green never goes directly to red.
  - FORCE_HOLD: State held at R0 and prescaler held at 0. Entered directly, with State forced to R0, when ForceRed=1 in yellow (after yellow completes) or in red (next edge). When ForceRed=0, return to RUN; a full red_len window starts from R0.
- Ped latch:
  - Set by PedReq=1 on any cycle and sticky until serviced.
  - A request arriving in yellow/red, or during FORCE_*, is serviced in the next green once State ≥ min_green-1.
  - PedReq during green already at State ≥ G_LEN-1: normal advance, no PedAck, latch cleared by the entry into yellow.
- Simultaneous events:
  - ForceRed beats a pedestrian jump; the latch is kept.
  - rst beats everything.
  - Enable=0 with ForceRed=1 in red still forces State to R0 and holds.
  - Enable=0 with ForceRed=1 in green still jumps to Y0, but yellow stays frozen until Enable=1.

Test Plan:
1. Reset, then Enable=1, tick_div=1 → State goes 10,11,…,15,0,1,…; Green for 0–7, Yellow for 8–9, Red for 10–15; wraps 15→0; exactly one colour high every cycle.
2. tick_div=15, Enable toggled low for 7 cycles mid-window → Tick spacing is 15 enabled cycles; State frozen while Enable=0; no lost or extra ticks.
3. PedReq pulse at State=0 (tick_div=1) → State goes 0,1,8; PedAck high exactly on the edge State becomes 8; a second PedReq at State=9 gets PedAck at State=1→8 in the next cycle.
4. ForceRed=1 at State=4 → State goes to 8, then 9, then holds at 10 with Red=1. Release after 20 cycles → State goes 10..15,0.
5. ForceRed=1 at State=12 → State=10 on the next edge and held. PedReq during the hold is serviced after release at State=1.
6. rst asserted at State=5 with ped latch set → next edge State=10, Red=1, PedAck=0, latch cleared; no PedAck in the following green.

Source files
------------

// File: rtl/traffic_state_gen.sv
// rtl/traffic_state_gen.sv - traffic-light State code generator with pedestrian and force-red handling
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   Enable   in   gates the tick prescaler
//   PedReq   in   pedestrian request (pulse or level), latched until serviced
//   ForceRed in   level; walk through yellow if needed, then hold red
//   State    out  cycle position code for the decoder
//   Red      out  registered red indication
//   Yellow   out  registered yellow indication
//   Green    out  registered green indication
//   Tick     out  one-cycle pulse on each prescaler wrap
//   PedAck   out  one-cycle pulse when a latched request shortens green
module traffic_state_gen #(
  parameter int num_of_bit         = 4,
  parameter int green_yellow_ratio = 4,
  parameter int yellow_len         = 2,
  parameter int red_len            = 6,
  parameter int tick_div           = 15,
  parameter int min_green          = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Enable,
  input  logic                  PedReq,
  input  logic                  ForceRed,
  output logic [num_of_bit-1:0] State,
  output logic                  Red,
  output logic                  Yellow,
  output logic                  Green,
  output logic                  Tick,
  output logic                  PedAck
);

  localparam int G_LEN = green_yellow_ratio * yellow_len;
  localparam int Y0    = G_LEN;
  localparam int R0    = G_LEN + yellow_len;
  localparam int CYCLE = R0 + red_len;
  localparam int PW    = (tick_div > 1) ? $clog2(tick_div) : 1;

  generate
    if ((CYCLE > (1 << num_of_bit)) || (min_green > G_LEN) || (min_green < 1)) begin : g_param_err
      $error("traffic_state_gen: illegal parameter combination");
    end
  endgenerate

  localparam logic [num_of_bit-1:0] Y0_C    = num_of_bit'(Y0);
  localparam logic [num_of_bit-1:0] R0_C    = num_of_bit'(R0);
  localparam logic [num_of_bit-1:0] LAST_C  = num_of_bit'(CYCLE - 1);
  localparam logic [num_of_bit-1:0] GLAST_C = num_of_bit'(G_LEN - 1);
  localparam logic [num_of_bit-1:0] YLAST_C = num_of_bit'(R0 - 1);
  localparam logic [num_of_bit-1:0] MING_C  = num_of_bit'(min_green - 1);
  localparam logic [PW-1:0]         TOP_C   = PW'(tick_div - 1);

  typedef enum logic [1:0] {RUN, FORCE_Y, FORCE_HOLD} mode_t;

  mode_t                 mode_q, mode_d;
  logic [num_of_bit-1:0] state_q, state_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic                  latch_q, latch_d;
  logic                  red_q, yellow_q, green_q, tick_q, ack_q;
  logic                  tick_d, ack_d;
  logic                  tick_cond, s_green, s_yellow, yellow_forced;

  assign tick_cond = Enable && (presc_q == TOP_C);
  assign s_green   = state_q < Y0_C;
  assign s_yellow  = (state_q >= Y0_C) && (state_q < R0_C);
  // Yellow under force keeps its normal timing; only its exit is redirected.
  assign yellow_forced = (mode_q == FORCE_Y) || ((mode_q == RUN) && ForceRed && s_yellow);

  always_comb begin
    mode_d  = mode_q;
    state_d = state_q;
    presc_d = presc_q;
    latch_d = latch_q | PedReq;
    ack_d   = 1'b0;
    tick_d  = tick_cond && (mode_q != FORCE_HOLD);
    if (Enable) begin
      presc_d = tick_cond ? '0 : presc_q + 1'b1;
    end

    if (mode_q == FORCE_HOLD) begin
      state_d = R0_C;
      presc_d = '0;
      if (!ForceRed) begin
        mode_d = RUN;
      end
    end else if (yellow_forced) begin
      mode_d = FORCE_Y;
      if (tick_cond) begin
        if (state_q == YLAST_C) begin
          state_d = R0_C;
          if (ForceRed) begin
            mode_d  = FORCE_HOLD;
            presc_d = '0;
          end else begin
            mode_d = RUN;
          end
        end else begin
          state_d = state_q + 1'b1;
        end
      end
    end else if (ForceRed && s_green) begin
      // Jump straight to yellow; the ped latch is deliberately kept.
      state_d = Y0_C;
      mode_d  = FORCE_Y;
    end else if (ForceRed) begin
      state_d = R0_C;
      mode_d  = FORCE_HOLD;
      presc_d = '0;
    end else if (tick_cond) begin
      // Jump only when it actually shortens green; at the last green tick
      // the normal advance already lands on yellow.
      if (latch_q && s_green && (state_q >= MING_C) && (state_q < GLAST_C)) begin
        state_d = Y0_C;
        ack_d   = 1'b1;
        latch_d = 1'b0;
      end else begin
        state_d = (state_q == LAST_C) ? '0 : state_q + 1'b1;
        if (state_q == GLAST_C) begin
          latch_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= RUN;
      state_q  <= R0_C;
      presc_q  <= '0;
      latch_q  <= 1'b0;
      red_q    <= 1'b1;
      yellow_q <= 1'b0;
      green_q  <= 1'b0;
      tick_q   <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      state_q  <= state_d;
      presc_q  <= presc_d;
      latch_q  <= latch_d;
      // Colours decoded from the next State so they change on the same edge.
      green_q  <= state_d < Y0_C;
      yellow_q <= (state_d >= Y0_C) && (state_d < R0_C);
      red_q    <= state_d >= R0_C;
      tick_q   <= tick_d;
      ack_q    <= ack_d;
    end
  end

  assign State  = state_q;
  assign Red    = red_q;
  assign Yellow = yellow_q;
  assign Green  = green_q;
  assign Tick   = tick_q;
  assign PedAck = ack_q;

endmodule

// File: tb/tb_traffic_state_gen.sv
// tb/tb_traffic_state_gen.sv - directed self-checking bench for traffic_state_gen
module tb_traffic_state_gen;

  logic       clk = 1'b0;
  logic       rst, Enable, PedReq, ForceRed;
  logic [3:0] st1, st15;
  logic       r1, y1, g1, tk1, ack1;
  logic       r15, y15, g15, tk15, ack15;
  int         n_run = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  traffic_state_gen #(.tick_div(1)) dut (
    .clk(clk), .rst(rst), .Enable(Enable), .PedReq(PedReq), .ForceRed(ForceRed),
    .State(st1), .Red(r1), .Yellow(y1), .Green(g1), .Tick(tk1), .PedAck(ack1)
  );

  traffic_state_gen #(.tick_div(15)) dut15 (
    .clk(clk), .rst(rst), .Enable(Enable), .PedReq(PedReq), .ForceRed(ForceRed),
    .State(st15), .Red(r15), .Yellow(y15), .Green(g15), .Tick(tk15), .PedAck(ack15)
  );

  function automatic logic [2:0] col(input logic [3:0] s);
    if (s < 4'd8) return 3'b001;
    else if (s < 4'd10) return 3'b010;
    else return 3'b100;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; Enable = 1'b0; PedReq = 1'b0; ForceRed = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_run++;
    if (st1 !== 4'd10 || {r1, y1, g1} !== 3'b100 || tk1 !== 1'b0 || ack1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_dut1: got st=%0d ryg=%b tick=%b ack=%b expected st=10 ryg=100 tick=0 ack=0",
               st1, {r1, y1, g1}, tk1, ack1);
    end
    n_run++;
    if (st15 !== 4'd10 || {r15, y15, g15} !== 3'b100 || tk15 !== 1'b0 || ack15 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_dut15: got st=%0d ryg=%b tick=%b ack=%b expected st=10 ryg=100 tick=0 ack=0",
               st15, {r15, y15, g15}, tk15, ack15);
    end
  endtask

  task automatic test_run_wrap();
    logic [3:0] e;
    do_reset();
    Enable = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      step();
      e = 4'((10 + k) % 16);
      n_run++;
      if (st1 !== e || {r1, y1, g1} !== col(e) || tk1 !== 1'b1) begin
        n_fail++;
        $display("FAIL run_wrap k=%0d: got st=%0d ryg=%b tick=%b expected st=%0d ryg=%b tick=1",
                 k, st1, {r1, y1, g1}, tk1, e, col(e));
      end
    end
  endtask

  task automatic test_enable_gating();
    int         en_cnt;
    int         ticks;
    logic       et;
    logic [3:0] es;
    do_reset();
    en_cnt = 0;
    ticks = 0;
    for (int c = 1; c <= 60; c++) begin
      Enable = (c >= 20 && c <= 26) ? 1'b0 : 1'b1;
      step();
      if (Enable) en_cnt++;
      et = Enable && (en_cnt % 15 == 0);
      es = 4'((10 + en_cnt / 15) % 16);
      if (tk15) ticks++;
      n_run++;
      if (tk15 !== et || st15 !== es || {r15, y15, g15} !== col(es)) begin
        n_fail++;
        $display("FAIL enable_gating c=%0d: got tick=%b st=%0d ryg=%b expected tick=%b st=%0d ryg=%b",
                 c, tk15, st15, {r15, y15, g15}, et, es, col(es));
      end
    end
    n_run++;
    if (ticks != 3) begin
      n_fail++;
      $display("FAIL enable_tick_count: got %0d expected 3", ticks);
    end
  endtask

  task automatic test_ped();
    logic [3:0] seq [9] = '{4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0, 4'd1, 4'd8};
    do_reset();
    Enable = 1'b1;
    repeat (6) step();
    n_run++;
    if (st1 !== 4'd0) begin
      n_fail++;
      $display("FAIL ped_start: got st=%0d expected 0", st1);
    end
    PedReq = 1'b1;
    step();
    PedReq = 1'b0;
    n_run++;
    if (st1 !== 4'd1 || ack1 !== 1'b0) begin
      n_fail++;
      $display("FAIL ped_first_step: got st=%0d ack=%b expected st=1 ack=0", st1, ack1);
    end
    step();
    n_run++;
    if (st1 !== 4'd8 || ack1 !== 1'b1 || {r1, y1, g1} !== 3'b010) begin
      n_fail++;
      $display("FAIL ped_jump: got st=%0d ack=%b ryg=%b expected st=8 ack=1 ryg=010", st1, ack1, {r1, y1, g1});
    end
    step();
    n_run++;
    if (st1 !== 4'd9 || ack1 !== 1'b0) begin
      n_fail++;
      $display("FAIL ped_after_jump: got st=%0d ack=%b expected st=9 ack=0", st1, ack1);
    end
    PedReq = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      PedReq = 1'b0;
      n_run++;
      if (st1 !== seq[i] || ack1 !== (i == 8)) begin
        n_fail++;
        $display("FAIL ped_yellow_req i=%0d: got st=%0d ack=%b expected st=%0d ack=%b",
                 i, st1, ack1, seq[i], (i == 8));
      end
    end
  endtask

  task automatic test_ped_late();
    logic [3:0] e;
    do_reset();
    Enable = 1'b1;
    repeat (13) step();
    n_run++;
    if (st1 !== 4'd7) begin
      n_fail++;
      $display("FAIL ped_late_start: got st=%0d expected 7", st1);
    end
    PedReq = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      step();
      PedReq = 1'b0;
      e = 4'((7 + k) % 16);
      n_run++;
      if (st1 !== e || ack1 !== 1'b0) begin
        n_fail++;
        $display("FAIL ped_late k=%0d: got st=%0d ack=%b expected st=%0d ack=0", k, st1, ack1, e);
      end
    end
  endtask

  task automatic test_force_green();
    logic [3:0] rel [7] = '{4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0};
    do_reset();
    Enable = 1'b1;
    repeat (10) step();
    n_run++;
    if (st1 !== 4'd4) begin
      n_fail++;
      $display("FAIL fg_start: got st=%0d expected 4", st1);
    end
    ForceRed = 1'b1;
    step();
    n_run++;
    if (st1 !== 4'd8 || {r1, y1, g1} !== 3'b010) begin
      n_fail++;
      $display("FAIL fg_to_yellow: got st=%0d ryg=%b expected st=8 ryg=010", st1, {r1, y1, g1});
    end
    step();
    n_run++;
    if (st1 !== 4'd9 || {r1, y1, g1} !== 3'b010) begin
      n_fail++;
      $display("FAIL fg_yellow2: got st=%0d ryg=%b expected st=9 ryg=010", st1, {r1, y1, g1});
    end
    for (int k = 0; k <= 20; k++) begin
      step();
      n_run++;
      if (st1 !== 4'd10 || {r1, y1, g1} !== 3'b100) begin
        n_fail++;
        $display("FAIL fg_hold k=%0d: got st=%0d ryg=%b expected st=10 ryg=100", k, st1, {r1, y1, g1});
      end
    end
    ForceRed = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      n_run++;
      if (st1 !== rel[i]) begin
        n_fail++;
        $display("FAIL fg_release i=%0d: got st=%0d expected %0d", i, st1, rel[i]);
      end
    end
  endtask

  task automatic test_force_red();
    logic [3:0] rel [9] = '{4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0, 4'd1, 4'd8};
    do_reset();
    Enable = 1'b1;
    repeat (2) step();
    n_run++;
    if (st1 !== 4'd12) begin
      n_fail++;
      $display("FAIL fr_start: got st=%0d expected 12", st1);
    end
    ForceRed = 1'b1;
    for (int k = 0; k < 8; k++) begin
      PedReq = (k == 3);
      step();
      n_run++;
      if (st1 !== 4'd10 || r1 !== 1'b1 || ack1 !== 1'b0) begin
        n_fail++;
        $display("FAIL fr_hold k=%0d: got st=%0d red=%b ack=%b expected st=10 red=1 ack=0", k, st1, r1, ack1);
      end
    end
    PedReq = 1'b0;
    ForceRed = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      n_run++;
      if (st1 !== rel[i] || ack1 !== (i == 8)) begin
        n_fail++;
        $display("FAIL fr_release i=%0d: got st=%0d ack=%b expected st=%0d ack=%b",
                 i, st1, ack1, rel[i], (i == 8));
      end
    end
  endtask

  task automatic test_force_disabled();
    logic [3:0] seq [8] = '{4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd9, 4'd10, 4'd10};
    do_reset();
    Enable = 1'b1;
    repeat (8) step();
    Enable = 1'b0;
    ForceRed = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) Enable = 1'b1;
      step();
      n_run++;
      if (st1 !== seq[i]) begin
        n_fail++;
        $display("FAIL force_disabled i=%0d: got st=%0d expected %0d", i, st1, seq[i]);
      end
    end
    ForceRed = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [3:0] e;
    do_reset();
    Enable = 1'b1;
    repeat (11) step();
    Enable = 1'b0;
    PedReq = 1'b1;
    step();
    PedReq = 1'b0;
    n_run++;
    if (st1 !== 4'd5) begin
      n_fail++;
      $display("FAIL rm_frozen: got st=%0d expected 5", st1);
    end
    rst = 1'b1;
    step();
    n_run++;
    if (st1 !== 4'd10 || {r1, y1, g1} !== 3'b100 || ack1 !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_reset: got st=%0d ryg=%b ack=%b expected st=10 ryg=100 ack=0", st1, {r1, y1, g1}, ack1);
    end
    rst = 1'b0;
    Enable = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step();
      e = 4'((10 + k) % 16);
      n_run++;
      if (st1 !== e || ack1 !== 1'b0) begin
        n_fail++;
        $display("FAIL rm_after k=%0d: got st=%0d ack=%b expected st=%0d ack=0", k, st1, ack1, e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_run_wrap();
    test_enable_gating();
    test_ped();
    test_ped_late();
    test_force_green();
    test_force_red();
    test_force_disabled();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
